// File: rtl/quad_upconverter_par.sv
// fs/4 quadrature upconverter: buffers 1-bit I/Q pairs in a primed FIFO and emits one LANES-bit word per aclk.
// Optional underrun statistics counter is built only when UPCONV_STATS_EN is defined.
module quad_upconverter_par #(
    parameter int LANES       = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_i,
    input  logic             s_q,
    output logic [LANES-1:0] out_word,
    output logic             running,
    output logic             underrun,
    output logic [15:0]      underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if ((LANES % 4) != 0 || LANES < 4) begin : g_lanes_chk
        $error("LANES must be a positive multiple of 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (PRIME_LEVEL < 1 || PRIME_LEVEL > FIFO_DEPTH) begin : g_prime_chk
        $error("PRIME_LEVEL must be in 1..FIFO_DEPTH");
    end

    typedef enum logic {IDLE, RUN} state_t;

    // Alternating pattern starting with 0 at bit 0: mid-scale, zero-mean filler.
    function automatic logic [LANES-1:0] idle_word_f();
        logic [LANES-1:0] w;
        for (int k = 0; k < LANES; k++) w[k] = ((k % 2) == 1);
        return w;
    endfunction

    function automatic logic [LANES-1:0] map_word(input logic [1:0] iq, input logic [1:0] m);
        logic [3:0]       nib;
        logic [LANES-1:0] w;
        logic             i;
        logic             q;
        i = iq[1];
        q = iq[0];
        case (m)
            2'd0:    nib = {q, ~i, ~q, i};
            2'd1:    nib = {~q, ~i, q, i};
            2'd2:    nib = {~i, i, ~i, i};
            default: nib = {4{i}};
        endcase
        for (int k = 0; k < LANES; k++) w[k] = nib[2'(k % 4)];
        return w;
    endfunction

    localparam logic [LANES-1:0] IDLE_WORD = idle_word_f();

    state_t           state_q, state_d;
    logic [1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [1:0]       head;
    logic             push, pop, flush, ur_d;
    logic [LANES-1:0] word_d;

    assign s_ready = !rst && en && (count < CW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign head    = fifo_mem[rd_ptr];
    assign flush   = !en;
    assign running = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        ur_d    = 1'b0;
        word_d  = IDLE_WORD;
        case (state_q)
            IDLE: begin
                if (en && count >= CW'(PRIME_LEVEL)) begin
                    pop     = 1'b1;
                    word_d  = map_word(head, mode);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count != '0) begin
                    pop    = 1'b1;
                    word_d = map_word(head, mode);
                end else begin
                    state_d = IDLE;
                    ur_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: FSM, pointers, occupancy, output word and pulse.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_word <= IDLE_WORD;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_word <= word_d;
            underrun <= ur_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Pair storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr] <= {s_i, s_q};
    end

`ifdef UPCONV_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] ucnt;

    always_ff @(posedge aclk) begin
        if (rst)       ucnt <= '0;
        else if (ur_d) ucnt <= sat_inc(ucnt);
    end

    assign underrun_cnt = ucnt;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_quad_upconverter_par.sv
// Scoreboard bench for quad_upconverter_par: two instances (LANES=4/PRIME=1 and LANES=8/PRIME=4) on shared stimulus.
module tb_quad_upconverter_par;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        s_valid = 1'b0;
    logic        s_i = 1'b0;
    logic        s_q = 1'b0;
    logic        s_ready_a, s_ready_b;
    logic [3:0]  out_word_a;
    logic [7:0]  out_word_b;
    logic        running_a, running_b, underrun_a, underrun_b;
    logic [15:0] underrun_cnt_a, underrun_cnt_b;

    always #5 aclk = ~aclk;

    quad_upconverter_par #(.LANES(4), .FIFO_DEPTH(4), .PRIME_LEVEL(1)) u_a (
        .aclk(aclk), .rst(rst), .en(en), .mode(mode), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_i(s_i), .s_q(s_q), .out_word(out_word_a), .running(running_a),
        .underrun(underrun_a), .underrun_cnt(underrun_cnt_a)
    );

    quad_upconverter_par #(.LANES(8), .FIFO_DEPTH(4), .PRIME_LEVEL(4)) u_b (
        .aclk(aclk), .rst(rst), .en(en), .mode(mode), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_i(s_i), .s_q(s_q), .out_word(out_word_b), .running(running_b),
        .underrun(underrun_b), .underrun_cnt(underrun_cnt_b)
    );

    typedef struct packed {
        logic [3:0]  w_a;
        logic [7:0]  w_b;
        logic        run_a, run_b, ur_a, ur_b;
        logic [15:0] uc_a, uc_b;
    } exp_t;

    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [1:0]  mq [2][$];
    int          prime [2] = '{1, 4};
    int          lanes [2] = '{4, 8};
    logic        st_m [2] = '{1'b0, 1'b0};
    logic [15:0] uc_m [2] = '{16'd0, 16'd0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] idle_exp(input int nl);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < nl; k++) r[k] = ((k % 2) == 1);
        return r;
    endfunction

    function automatic logic [7:0] map_exp(input logic [1:0] iq, input logic [1:0] m, input int nl);
        logic [7:0] r;
        logic       ii, qq;
        ii = iq[1];
        qq = iq[0];
        r  = '0;
        for (int k = 0; k < nl; k++) begin
            case (m)
                2'd0: r[k] = (k % 4 == 0) ? ii : (k % 4 == 1) ? ~qq : (k % 4 == 2) ? ~ii : qq;
                2'd1: r[k] = (k % 4 == 0) ? ii : (k % 4 == 1) ? qq  : (k % 4 == 2) ? ~ii : ~qq;
                2'd2: r[k] = (k % 2 == 0) ? ii : ~ii;
                default: r[k] = ii;
            endcase
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic v, input logic i, input logic q);
        logic       rdy [2];
        logic [7:0] w_m [2];
        logic       ur_m [2];
        exp_t       ex;
        exp_t       got;
        @(negedge aclk);
        rst = r; en = e; mode = m; s_valid = v; s_i = i; s_q = q;
        #1;
        for (int n = 0; n < 2; n++) rdy[n] = !r && e && (mq[n].size() < 4);
        check_eq("s_ready_a", {31'd0, s_ready_a}, {31'd0, rdy[0]});
        check_eq("s_ready_b", {31'd0, s_ready_b}, {31'd0, rdy[1]});
        for (int n = 0; n < 2; n++) begin
            int c;
            c = mq[n].size();
            w_m[n]  = idle_exp(lanes[n]);
            ur_m[n] = 1'b0;
            if (r) begin
                mq[n].delete();
                st_m[n] = 1'b0;
                uc_m[n] = 16'd0;
            end else begin
                if (!e) begin
                    mq[n].delete();
                    st_m[n] = 1'b0;
                end else if (!st_m[n]) begin
                    if (c >= prime[n]) begin
                        w_m[n]  = map_exp(mq[n].pop_front(), m, lanes[n]);
                        st_m[n] = 1'b1;
                    end
                end else if (c > 0) begin
                    w_m[n] = map_exp(mq[n].pop_front(), m, lanes[n]);
                end else begin
                    st_m[n] = 1'b0;
                    ur_m[n] = 1'b1;
                    if (uc_m[n] != 16'hFFFF) uc_m[n] = uc_m[n] + 16'd1;
                end
                if (v && rdy[n]) mq[n].push_back({i, q});
            end
        end
        ex.w_a = w_m[0][3:0];
        ex.w_b = w_m[1];
        ex.run_a = st_m[0];
        ex.run_b = st_m[1];
        ex.ur_a = ur_m[0];
        ex.ur_b = ur_m[1];
`ifdef UPCONV_STATS_EN
        ex.uc_a = uc_m[0];
        ex.uc_b = uc_m[1];
`else
        ex.uc_a = 16'd0;
        ex.uc_b = 16'd0;
`endif
        sb.push_back(ex);
        @(posedge aclk);
        #1;
        got = sb.pop_front();
        check_eq("out_word_a", {28'd0, out_word_a}, {28'd0, got.w_a});
        check_eq("out_word_b", {24'd0, out_word_b}, {24'd0, got.w_b});
        check_eq("running_a", {31'd0, running_a}, {31'd0, got.run_a});
        check_eq("running_b", {31'd0, running_b}, {31'd0, got.run_b});
        check_eq("underrun_a", {31'd0, underrun_a}, {31'd0, got.ur_a});
        check_eq("underrun_b", {31'd0, underrun_b}, {31'd0, got.ur_b});
        check_eq("underrun_cnt_a", {16'd0, underrun_cnt_a}, {16'd0, got.uc_a});
        check_eq("underrun_cnt_b", {16'd0, underrun_cnt_b}, {16'd0, got.uc_b});
    endtask

    initial begin
        // Reset
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

        // Single USB pair, then let instance A underrun
        step(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

        // Back-to-back LSB stream of (1,1)
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);

        // Mode change USB -> FS2 mid-stream
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 2'd0, 1'b1, 1'(k), 1'(k >> 1));
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'(k));
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);

        // Disabled producer, fill, then drop en during RUN
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 2'd0, 1'b1, 1'(k), 1'b1);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

        // BYPASS with I=1, then reset mid-RUN
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);

        // Bursty random traffic with repeated underruns
        for (int k = 0; k < 60; k++)
            step(1'b0, 1'($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
